pos_read_controller: RTL and testbench

Read-side sequencer for one PE's position datapath: generates cell-memory read addresses plus the `phase`, `reading_particle_num`, `pause_reading`, `particle_id` and `ref_id` control stream consumed by the position preprocessor.

---
 rtl/pos_read_controller.sv | 190 +++++++++++++++++++
 tb/tb_pos_read_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_read_controller.sv
// Read-side sequencer for one PE's position datapath: walks the count words, then every
// (reference, neighbor slot, phase) triple, and closes each sweep and the job with past-the-end IDs.
module pos_read_controller #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int WAIT_CYCLES       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         back_pressure,
    input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic                         phase,
    output logic                         reading_particle_num,
    output logic                         pause_reading,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         busy,
    output logic                         done,
    output logic                         count_err
);

    localparam int W   = PARTICLE_ID_WIDTH;
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);
    localparam logic [W-1:0]   CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ_NUM, S_WAIT, S_SWEEP, S_END_SWEEP, S_FINISH, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   rd_addr_q, rd_addr_d;
    logic [W-1:0]   particle_id_q, particle_id_d;
    logic [W-1:0]   ref_id_q, ref_id_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           phase_q, phase_d;
    logic           rnum_q, rnum_d;
    logic           pause_q, pause_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           count_err_q, count_err_d;
    logic           frozen;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= S_IDLE;
            rd_addr_q     <= '0;
            particle_id_q <= '0;
            ref_id_q      <= '0;
            cnt_q         <= '0;
            wait_cnt_q    <= '0;
            phase_q       <= 1'b0;
            rnum_q        <= 1'b0;
            pause_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            count_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            particle_id_q <= particle_id_d;
            ref_id_q      <= ref_id_d;
            cnt_q         <= cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            phase_q       <= phase_d;
            rnum_q        <= rnum_d;
            pause_q       <= pause_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            count_err_q   <= count_err_d;
        end
    end

    // A registered pause freezes the read stream everywhere except IDLE and DONE.
    assign frozen = pause_q && (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        particle_id_d = particle_id_q;
        ref_id_d      = ref_id_q;
        cnt_d         = cnt_q;
        wait_cnt_d    = wait_cnt_q;
        phase_d       = phase_q;
        rnum_d        = rnum_q;
        count_err_d   = count_err_q;
        pause_d       = back_pressure;

        if (!frozen) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d       = S_READ_NUM;
                        rnum_d        = 1'b1;
                        rd_addr_d     = '0;
                        phase_d       = 1'b0;
                        particle_id_d = '0;
                        ref_id_d      = '0;
                    end
                end
                S_READ_NUM: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        phase_d    = 1'b0;
                        rnum_d     = 1'b0;
                        wait_cnt_d = '0;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        cnt_d = ref_particle_count;
                        if (ref_particle_count == '0) begin
                            state_d = S_DONE;
                        end else if (ref_particle_count == CNT_MAX) begin
                            // cnt+1 would wrap, so the past-the-end IDs could not be formed.
                            count_err_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d       = S_SWEEP;
                            ref_id_d      = W'(1);
                            particle_id_d = W'(1);
                            rd_addr_d     = W'(1);
                            phase_d       = 1'b0;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d       = 1'b0;
                        particle_id_d = particle_id_q + 1'b1;
                        rd_addr_d     = particle_id_q + 1'b1;
                        if (particle_id_q == cnt_q) begin
                            state_d = S_END_SWEEP;
                        end
                    end
                end
                S_END_SWEEP: begin
                    if (ref_id_q < cnt_q) begin
                        state_d       = S_SWEEP;
                        ref_id_d      = ref_id_q + 1'b1;
                        particle_id_d = W'(1);
                        rd_addr_d     = W'(1);
                        phase_d       = 1'b0;
                    end else begin
                        state_d  = S_FINISH;
                        ref_id_d = cnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d       = S_IDLE;
                    rd_addr_d     = '0;
                    particle_id_d = '0;
                    ref_id_d      = '0;
                    phase_d       = 1'b0;
                    rnum_d        = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign rd_addr              = rd_addr_q;
    assign phase                = phase_q;
    assign reading_particle_num = rnum_q;
    assign pause_reading        = pause_q;
    assign particle_id          = particle_id_q;
    assign ref_id               = ref_id_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign count_err            = count_err_q;

endmodule

// File: tb/tb_pos_read_controller.sv
// Bench for pos_read_controller: builds each job's expected cycle trace from nested loops over
// references and neighbor slots, then replays it against the DUT with scheduled back-pressure.
module tb_pos_read_controller;

    localparam int W    = 7;
    localparam int WC   = 2;
    localparam int MAXV = (1 << W) - 1;
    localparam int NSCH = 1024;

    logic         clk = 1'b0;
    logic         rst, start, back_pressure;
    logic [W-1:0] ref_particle_count;
    logic [W-1:0] rd_addr, particle_id, ref_id;
    logic         phase, reading_particle_num, pause_reading, busy, done, count_err;

    always #5 clk = ~clk;

    pos_read_controller #(.PARTICLE_ID_WIDTH(W), .WAIT_CYCLES(WC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .back_pressure       (back_pressure),
        .ref_particle_count  (ref_particle_count),
        .rd_addr             (rd_addr),
        .phase               (phase),
        .reading_particle_num(reading_particle_num),
        .pause_reading       (pause_reading),
        .particle_id         (particle_id),
        .ref_id              (ref_id),
        .busy                (busy),
        .done                (done),
        .count_err           (count_err)
    );

    // One expected cycle; chk_* masks out fields whose value is not defined in that cycle.
    typedef struct {
        bit rnum, busy, done, err, freeze;
        bit chk_addr, chk_phase, chk_pid, chk_ref;
        int addr;
        bit phase;
        int pid, ref_id;
    } frame_t;

    frame_t exp_q[$];
    bit     bp_sched[NSCH];
    bit     start_sched[NSCH];
    bit     err_model;
    int     checks, errors;

    function automatic frame_t mk(bit rnum, bit bsy, bit dn, bit frz, bit ca, int addr,
                                  bit cp, bit ph, bit cpid, int pid, bit cref, int rid);
        frame_t f;
        f.rnum = rnum; f.busy = bsy; f.done = dn; f.freeze = frz; f.err = 1'b0;
        f.chk_addr = ca; f.addr = addr; f.chk_phase = cp; f.phase = ph;
        f.chk_pid = cpid; f.pid = pid; f.chk_ref = cref; f.ref_id = rid;
        return f;
    endfunction

    // Unpaused trace of a job with home-cell count n, ending with one IDLE cycle.
    task automatic build_frames(input int n);
        bit ovf;
        ovf = (n == MAXV);
        exp_q.delete();
        exp_q.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0));
        exp_q.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0));
        for (int i = 0; i < WC; i++) exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        if (n != 0 && !ovf) begin
            for (int r = 1; r <= n; r++) begin
                for (int p = 1; p <= n; p++)
                    for (int ph = 0; ph < 2; ph++)
                        exp_q.push_back(mk(0, 1, 0, 1, 1, p, 1, ph[0], 1, p, 1, r));
                exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 1, n + 1, 1, r));
            end
            exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, n + 1));
        end
        exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0));
        for (int i = 0; i < exp_q.size(); i++)
            exp_q[i].err = (i >= exp_q.size() - 2) ? (err_model | ovf) : err_model;
        err_model = err_model | ovf;
    endtask

    // Starts a job and replays its trace; cycle 0 is the first READ_NUM cycle.
    // When rst_cycle is reached, rst is raised for that cycle and the task returns early.
    task automatic run_job(input int n, input int rst_cycle, output int done_cycle);
        int     idx, cyc;
        bit     prev_bp, aborted;
        frame_t e;
        build_frames(n);
        ref_particle_count = W'(n);
        back_pressure = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0; prev_bp = 1'b0; aborted = 1'b0; done_cycle = -1;
        while (idx < exp_q.size() && cyc < 2000 && !aborted) begin
            e = exp_q[idx];
            checks++;
            if (reading_particle_num !== e.rnum) begin
                errors++; $display("FAIL rnum cyc=%0d got=%b exp=%b", cyc, reading_particle_num, e.rnum);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy);
            end
            checks++;
            if (done !== e.done) begin
                errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e.done);
            end
            checks++;
            if (count_err !== e.err) begin
                errors++; $display("FAIL count_err cyc=%0d got=%b exp=%b", cyc, count_err, e.err);
            end
            checks++;
            if (pause_reading !== prev_bp) begin
                errors++; $display("FAIL pause cyc=%0d got=%b exp=%b", cyc, pause_reading, prev_bp);
            end
            if (e.chk_addr) begin
                checks++;
                if (rd_addr !== W'(e.addr)) begin
                    errors++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, rd_addr, e.addr);
                end
            end
            if (e.chk_phase) begin
                checks++;
                if (phase !== e.phase) begin
                    errors++; $display("FAIL phase cyc=%0d got=%b exp=%b", cyc, phase, e.phase);
                end
            end
            if (e.chk_pid) begin
                checks++;
                if (particle_id !== W'(e.pid)) begin
                    errors++; $display("FAIL particle_id cyc=%0d got=%0d exp=%0d", cyc, particle_id, e.pid);
                end
            end
            if (e.chk_ref) begin
                checks++;
                if (ref_id !== W'(e.ref_id)) begin
                    errors++; $display("FAIL ref_id cyc=%0d got=%0d exp=%0d", cyc, ref_id, e.ref_id);
                end
            end
            if (done === 1'b1 && done_cycle < 0) done_cycle = cyc;
            if (cyc == rst_cycle) begin
                rst = 1'b1;
                aborted = 1'b1;
            end else begin
                back_pressure = (cyc < NSCH) ? bp_sched[cyc] : 1'b0;
                start         = (cyc < NSCH) ? start_sched[cyc] : 1'b0;
                if (!(prev_bp && e.freeze)) idx++;
                prev_bp = back_pressure;
                @(posedge clk); #1;
                cyc++;
            end
        end
        back_pressure = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            checks++;
            if (idx < exp_q.size()) begin
                errors++; $display("FAIL job_timeout n=%0d got_idx=%0d exp_idx=%0d", n, idx, exp_q.size());
            end
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < NSCH; i++) begin
            bp_sched[i] = 1'b0;
            start_sched[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({rd_addr, phase, reading_particle_num, pause_reading, particle_id, ref_id, busy, done, count_err} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%0h exp=0", {rd_addr, phase, particle_id, ref_id, busy, done, count_err});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_beats_start got=%b exp=0", busy);
        end
        rst = 1'b0; start = 1'b0; err_model = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_n2();
        int dc;
        clear_sched();
        run_job(2, -1, dc);
        checks++;
        if (dc != 15) begin
            errors++; $display("FAIL n2_done_cycle got=%0d exp=15", dc);
        end
    endtask

    task automatic test_zero();
        int dc;
        clear_sched();
        run_job(0, -1, dc);
        checks++;
        if (dc != 4) begin
            errors++; $display("FAIL n0_done_cycle got=%0d exp=4", dc);
        end
        checks++;
        if (count_err !== 1'b0) begin
            errors++; $display("FAIL n0_count_err got=%b exp=0", count_err);
        end
    endtask

    task automatic test_overflow();
        int dc;
        clear_sched();
        run_job(MAXV, -1, dc);
        checks++;
        if (dc != 4) begin
            errors++; $display("FAIL ovf_done_cycle got=%0d exp=4", dc);
        end
        run_job(1, -1, dc);
        checks++;
        if (count_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b exp=1", count_err);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; err_model = 1'b0;
        checks++;
        if (count_err !== 1'b0) begin
            errors++; $display("FAIL ovf_rst_clear got=%b exp=0", count_err);
        end
    endtask

    task automatic test_pause();
        int dc;
        clear_sched();
        for (int i = 4; i < 7; i++) bp_sched[i] = 1'b1;
        run_job(1, -1, dc);
        checks++;
        if (dc != 11) begin
            errors++; $display("FAIL pause_done_cycle got=%0d exp=11", dc);
        end
        clear_sched();
    endtask

    task automatic test_reset_mid();
        int dc;
        clear_sched();
        run_job(3, 6, dc);
        @(posedge clk); #1;
        rst = 1'b0; err_model = 1'b0;
        checks++;
        if ({rd_addr, phase, reading_particle_num, pause_reading, particle_id, ref_id, busy, done, count_err} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got=%0h exp=0", {rd_addr, phase, particle_id, ref_id, busy, done});
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle got=%b%b exp=00", busy, done);
        end
        run_job(3, -1, dc);
        checks++;
        if (dc != 5 + 3 * 7) begin
            errors++; $display("FAIL mid_reset_replay got=%0d exp=%0d", dc, 5 + 3 * 7);
        end
    endtask

    task automatic test_start_while_busy();
        int dc;
        clear_sched();
        start_sched[1] = 1'b1; start_sched[5] = 1'b1;
        start_sched[9] = 1'b1; start_sched[14] = 1'b1;
        run_job(2, -1, dc);
        checks++;
        if (dc != 15) begin
            errors++; $display("FAIL busy_start_done_cycle got=%0d exp=15", dc);
        end
        clear_sched();
    endtask

    task automatic test_random();
        int dc, n;
        for (int it = 0; it < 8; it++) begin
            clear_sched();
            n = $urandom_range(0, 5);
            for (int i = 0; i < 400; i++) bp_sched[i] = ($urandom_range(0, 3) == 0);
            run_job(n, -1, dc);
            checks++;
            if (dc < 2 + WC) begin
                errors++; $display("FAIL rand_done_cycle n=%0d got=%0d exp>=%0d", n, dc, 2 + WC);
            end
        end
        clear_sched();
    endtask

    initial begin
        checks = 0; errors = 0; err_model = 1'b0;
        rst = 1'b1; start = 1'b0; back_pressure = 1'b0; ref_particle_count = '0;
        clear_sched();
        test_reset();
        test_n2();
        test_zero();
        test_overflow();
        test_pause();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
